// File: rtl/vector_operand_loader.sv
// vector_operand_loader: packs fp32 operand beats into 8-lane vectors for the PE, zero-padding short tails,
// with a one-deep completed-vector bank so the input side never sees a combinational path from out_ready.
module vector_operand_loader #(
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_a,
  input  logic [31:0]           in_b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_a,
  output logic [32*LANES-1:0]   out_b,
  output logic                  out_first,
  output logic                  out_last,
  output logic [3:0]            out_lanes,
  output logic [15:0]           vec_count
);
  logic [2:0]          lane_cnt;
  logic                pend;
  logic                first_nxt;
  logic                bank_last;
  logic [3:0]          bank_lanes;
  logic [32*LANES-1:0] bank_a, bank_b, nb_a, nb_b;
  logic                accept, done, free;
  assign in_ready = !pend;
  assign accept   = in_valid && !pend;
  assign done     = accept && (lane_cnt == 3'd7 || in_last);
  assign free     = !out_valid || out_ready;
  // Next bank image: write the incoming lane, and on completion clear every lane above it so padded products are +0.0.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign nb_a[32*l +: 32] = (accept && lane_cnt == 3'(l)) ? in_a :
                              (done && 3'(l) > lane_cnt) ? 32'd0 : bank_a[32*l +: 32];
    assign nb_b[32*l +: 32] = (accept && lane_cnt == 3'(l)) ? in_b :
                              (done && 3'(l) > lane_cnt) ? 32'd0 : bank_b[32*l +: 32];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt   <= '0;
      pend       <= 1'b0;
      first_nxt  <= 1'b1;
      bank_last  <= 1'b0;
      bank_lanes <= '0;
      bank_a     <= '0;
      bank_b     <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_lanes  <= '0;
      vec_count  <= '0;
    end else begin
      bank_a <= nb_a;
      bank_b <= nb_b;
      if (accept) lane_cnt <= done ? 3'd0 : lane_cnt + 3'd1;
      if (done) begin
        bank_last  <= in_last;
        bank_lanes <= {1'b0, lane_cnt} + 4'd1;
      end
      if (out_valid && out_ready) vec_count <= vec_count + 16'd1;
      if (done && free) begin
        out_a     <= nb_a;
        out_b     <= nb_b;
        out_last  <= in_last;
        out_lanes <= {1'b0, lane_cnt} + 4'd1;
        out_first <= first_nxt;
        first_nxt <= in_last;
        out_valid <= 1'b1;
      end else if (pend && out_ready) begin
        out_a     <= bank_a;
        out_b     <= bank_b;
        out_last  <= bank_last;
        out_lanes <= bank_lanes;
        out_first <= first_nxt;
        first_nxt <= bank_last;
        pend      <= 1'b0;
        out_valid <= 1'b1;
      end else begin
        if (done) pend <= 1'b1;
        if (out_ready) out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vector_operand_loader.sv
// tb_vector_operand_loader: directed scenarios with hand-computed expectations for the vector operand loader.
module tb_vector_operand_loader;
  logic         clk = 0, rst = 0;
  logic         in_valid = 0, in_ready, in_last = 0;
  logic [31:0]  in_a = 0, in_b = 0;
  logic         out_valid, out_ready = 1, out_first, out_last;
  logic [255:0] out_a, out_b;
  logic [3:0]   out_lanes;
  logic [15:0]  vec_count;
  int vecs = 0, miscompares = 0;
  localparam logic [31:0] FP [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                     32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  vector_operand_loader #(.LANES(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_first(out_first), .out_last(out_last), .out_lanes(out_lanes), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 0; in_valid = 0; in_last = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
  endtask

  // Offers one beat starting just after a rising edge; returns just after the edge that accepts it.
  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      vecs++; miscompares++;
      $display("FAIL beat_wait in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    in_valid = 1; in_a = a; in_b = b; in_last = last;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    vecs++; if (vec_count !== 16'd0) begin miscompares++; $display("FAIL rst_vec_count got %0d exp 0", vec_count); end
    vecs++; if (out_lanes !== 4'd0 || out_a !== '0 || out_b !== '0) begin miscompares++; $display("FAIL rst_payload lanes=%0d a=%h", out_lanes, out_a); end
  endtask

  task automatic test_full_vector();
    logic [255:0] ea;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      ea[32*i +: 32] = FP[i];
      beat(FP[i], 32'h40000000, i == 7);
    end
    vecs++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL full_out_valid got %b exp 1", out_valid); end
    vecs++; if (out_lanes !== 4'd8) begin miscompares++; $display("FAIL full_lanes got %0d exp 8", out_lanes); end
    vecs++; if (out_first !== 1'b1 || out_last !== 1'b1) begin miscompares++; $display("FAIL full_first_last got %b%b exp 11", out_first, out_last); end
    vecs++; if (out_a !== ea) begin miscompares++; $display("FAIL full_out_a got %h exp %h", out_a, ea); end
    vecs++; if (out_b !== {8{32'h40000000}}) begin miscompares++; $display("FAIL full_out_b got %h", out_b); end
    @(posedge clk); #1;
    vecs++; if (vec_count !== 16'd1) begin miscompares++; $display("FAIL full_vec_count got %0d exp 1", vec_count); end
    vecs++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL full_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_padding();
    beat(32'h11111111, 32'hAAAA0001, 0);
    beat(32'h22222222, 32'hAAAA0002, 0);
    beat(32'h33333333, 32'hAAAA0003, 1);
    vecs++; if (out_lanes !== 4'd3) begin miscompares++; $display("FAIL pad_lanes got %0d exp 3", out_lanes); end
    vecs++; if (out_a !== {160'd0, 96'h333333332222222211111111}) begin miscompares++; $display("FAIL pad_out_a got %h", out_a); end
    vecs++; if (out_b !== {160'd0, 96'hAAAA0003AAAA0002AAAA0001}) begin miscompares++; $display("FAIL pad_out_b got %h", out_b); end
    vecs++; if (out_last !== 1'b1 || out_first !== 1'b1) begin miscompares++; $display("FAIL pad_first_last got %b%b exp 11", out_first, out_last); end
    @(posedge clk); #1;
  endtask

  task automatic test_long_dot();
    for (int i = 0; i < 20; i++) begin
      beat(32'h1000 + i, 32'h2000 + i, i == 19);
      if (i == 7 || i == 15) begin
        vecs++; if (out_valid !== 1 || out_lanes !== 4'd8 || out_first !== (i == 7) || out_last !== 0)
          begin miscompares++; $display("FAIL long_vec%0d v=%b lanes=%0d first=%b last=%b", i / 8, out_valid, out_lanes, out_first, out_last); end
      end
    end
    vecs++; if (out_valid !== 1 || out_lanes !== 4'd4 || out_first !== 0 || out_last !== 1)
      begin miscompares++; $display("FAIL long_vec2 v=%b lanes=%0d first=%b last=%b exp 1 4 0 1", out_valid, out_lanes, out_first, out_last); end
    vecs++; if (out_a !== {128'd0, 128'h00001013000010120000101100001010}) begin miscompares++; $display("FAIL long_vec2_a got %h", out_a); end
    @(posedge clk); #1;
    vecs++; if (vec_count !== 16'd5) begin miscompares++; $display("FAIL long_vec_count got %0d exp 5", vec_count); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] v1, v2;
    for (int i = 0; i < 8; i++) begin v1[32*i +: 32] = 100 + i; v2[32*i +: 32] = 108 + i; end
    out_ready = 0;
    for (int i = 0; i < 16; i++) beat(100 + i, 200 + i, i == 15);
    vecs++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    vecs++; if (out_a !== v1 || out_first !== 1 || out_last !== 0) begin miscompares++; $display("FAIL bp_hold_v1 a=%h first=%b last=%b", out_a, out_first, out_last); end
    repeat (3) @(posedge clk); #1;
    vecs++; if (out_a !== v1 || out_valid !== 1 || in_ready !== 0) begin miscompares++; $display("FAIL bp_stable a=%h v=%b rdy=%b", out_a, out_valid, in_ready); end
    out_ready = 1;
    @(posedge clk); #1;
    vecs++; if (out_a !== v2 || out_valid !== 1 || out_first !== 0 || out_last !== 1)
      begin miscompares++; $display("FAIL bp_v2 a=%h v=%b first=%b last=%b", out_a, out_valid, out_first, out_last); end
    vecs++; if (in_ready !== 1'b1 || vec_count !== 16'd6) begin miscompares++; $display("FAIL bp_release rdy=%b cnt=%0d exp 1 6", in_ready, vec_count); end
    @(posedge clk); #1;
    vecs++; if (out_valid !== 1'b0 || vec_count !== 16'd7) begin miscompares++; $display("FAIL bp_drain v=%b cnt=%0d exp 0 7", out_valid, vec_count); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) beat(32'h9000 + i, 32'h9100 + i, 0);
    rst = 0; #1;
    vecs++; if (out_valid !== 0 || out_lanes !== 0 || out_first !== 0 || out_last !== 0 || out_a !== '0 || out_b !== '0)
      begin miscompares++; $display("FAIL mrst_outputs v=%b lanes=%0d first=%b last=%b", out_valid, out_lanes, out_first, out_last); end
    vecs++; if (vec_count !== 16'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mrst_state cnt=%0d rdy=%b exp 0 1", vec_count, in_ready); end
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) beat(32'h5000 + i, 32'h6000 + i, 0);
    vecs++; if (out_valid !== 1 || out_lanes !== 4'd8 || out_first !== 1 || out_last !== 0)
      begin miscompares++; $display("FAIL mrst_vec v=%b lanes=%0d first=%b last=%b exp 1 8 1 0", out_valid, out_lanes, out_first, out_last); end
    vecs++; if (out_a[31:0] !== 32'h5000 || out_a[255:224] !== 32'h5007) begin miscompares++; $display("FAIL mrst_vec_a got %h", out_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_count_wrap();
    do_reset();
    out_ready = 1; in_valid = 1; in_last = 1; in_a = 32'h7; in_b = 32'h8;
    repeat (100) @(posedge clk);
    #1;
    vecs++; if (vec_count !== 16'd99 || out_lanes !== 4'd1) begin miscompares++; $display("FAIL wrap_stream cnt=%0d lanes=%0d exp 99 1", vec_count, out_lanes); end
    repeat (65437) @(posedge clk);
    #1; in_valid = 0; in_last = 0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (vec_count !== 16'h0001) begin miscompares++; $display("FAIL wrap_vec_count got %h exp 0001", vec_count); end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_padding();
    test_long_dot();
    test_back_to_back();
    test_mid_reset();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
